image_scaler_engine: RTL and testbench

//  Parametrised frame scaler: reads a SRC_W x SRC_H source frame from ROM, writes the scaled frame to RAM.

---
 rtl/image_scaler_engine_pkg.sv | 40 ++++
 rtl/image_scaler_engine_addr_gen.sv | 73 +++++++
 rtl/image_scaler_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_image_scaler_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_scaler_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_scaler_engine_pkg
// Description : Shared constants for the frame scaler: algorithm codes, zoom
//               encodings, FSM state codes and the scale-shift helper.
// Revision    : 1.0  initial release
// ============================================================================
package image_scaler_engine_pkg;

    // Algorithm codes (algorithm input)
    localparam logic [1:0] c_alg_nn    = 2'b00;
    localparam logic [1:0] c_alg_repl  = 2'b01;
    localparam logic [1:0] c_alg_decim = 2'b10;
    localparam logic [1:0] c_alg_avg   = 2'b11;

    // Zoom encodings (zoom_level input)
    localparam logic [2:0] c_zoom_quarter = 3'd0;
    localparam logic [2:0] c_zoom_half    = 3'd1;
    localparam logic [2:0] c_zoom_one     = 3'd2;
    localparam logic [2:0] c_zoom_double  = 3'd3;
    localparam logic [2:0] c_zoom_quad    = 3'd4;
    localparam logic [2:0] c_max_zoom     = 3'd4;

    // FSM state codes
    localparam int unsigned   c_st_w      = 3;
    localparam logic [c_st_w-1:0] c_st_idle   = 3'd0;
    localparam logic [c_st_w-1:0] c_st_fetch  = 3'd1;
    localparam logic [c_st_w-1:0] c_st_drain  = 3'd2;
    localparam logic [c_st_w-1:0] c_st_emit   = 3'd3;
    localparam logic [c_st_w-1:0] c_st_finish = 3'd4;

    // Scale exponent k = |zoom - 1x|; only meaningful for zoom <= c_max_zoom.
    function automatic logic [1:0] zoom_shift(input logic [2:0] zoom);
        logic [2:0] d;
        d = (zoom >= c_zoom_one) ? (zoom - c_zoom_one) : (c_zoom_one - zoom);
        return d[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_scaler_engine_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : image_scaler_engine_addr_gen
// Description : Combinational source-address generator. Maps an output pixel
//               (x,y) plus tap index to a linear ROM address sy*SRC_W+sx.
// Ports       : i_x, i_y       output pixel coordinates
//               i_k            scale exponent (factor F = 1<<k)
//               i_zoom_in      1 when magnifying (coordinates shift down)
//               i_algorithm    scaling algorithm code
//               i_tap          raster tap index inside an averaging block
//               o_rd_addr      ROM address
// Revision    : 1.0  initial release
// ============================================================================
module image_scaler_engine_addr_gen
    import image_scaler_engine_pkg::*;
#(
    parameter int SRC_W = 160,
    parameter int RA_W  = 15,
    parameter int XW    = 10,
    parameter int YW    = 9
)(
    input  logic [XW-1:0]   i_x,
    input  logic [YW-1:0]   i_y,
    input  logic [1:0]      i_k,
    input  logic            i_zoom_in,
    input  logic [1:0]      i_algorithm,
    input  logic [3:0]      i_tap,
    output logic [RA_W-1:0] o_rd_addr
);

    localparam logic [RA_W-1:0] c_src_w = RA_W'(SRC_W);

    logic [XW-1:0]   w_x_dn;
    logic [YW-1:0]   w_y_dn;
    logic [3:0]      w_f;
    logic [RA_W-1:0] w_sx;
    logic [RA_W-1:0] w_sy;
    logic [RA_W-1:0] w_half;
    logic [RA_W-1:0] w_tx;
    logic [RA_W-1:0] w_ty;

    always_comb begin
        w_f    = 4'd1 << i_k;
        w_half = RA_W'(w_f >> 1);
        // Tap index walks the FxF block in raster order.
        w_tx   = RA_W'(i_tap & (w_f - 4'd1));
        w_ty   = RA_W'(i_tap >> i_k);
        w_x_dn = i_x >> i_k;
        w_y_dn = i_y >> i_k;
        if (i_zoom_in) begin
            w_sx = RA_W'(w_x_dn);
            w_sy = RA_W'(w_y_dn);
        end else begin
            // Block top-left; at 1x (k=0) all offsets collapse to zero.
            w_sx = RA_W'(i_x) << i_k;
            w_sy = RA_W'(i_y) << i_k;
            case (i_algorithm)
                c_alg_nn: begin
                    w_sx = w_sx + w_half;
                    w_sy = w_sy + w_half;
                end
                c_alg_avg: begin
                    w_sx = w_sx + w_tx;
                    w_sy = w_sy + w_ty;
                end
                default: ;
            endcase
        end
        o_rd_addr = w_sy * c_src_w + w_sx;
    end

endmodule
`default_nettype wire

// File: rtl/image_scaler_engine.sv
`default_nettype none
// ============================================================================
// Module      : image_scaler_engine
// Description : Frame scaler. Reads a SRC_W x SRC_H frame from ROM and writes
//               the scaled frame (1/4x..4x; NN, replication, decimation,
//               block average) to RAM through a ready/valid write port.
// Ports       : clk, reset (async, active-high)
//               start/algorithm/zoom_level   frame request, cfg latched at start
//               rd_en/rd_addr/rd_data        ROM port, data RD_LAT cycles later
//               wr_valid/wr_ready/wr_addr/wr_data  RAM write port
//               busy/done/cfg_err            status
// Revision    : 1.0  initial release
// ============================================================================
module image_scaler_engine
    import image_scaler_engine_pkg::*;
#(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int RA_W   = 15,
    parameter int WA_W   = 19,
    parameter int RD_LAT = 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       algorithm,
    input  logic [2:0]       zoom_level,
    output logic             rd_en,
    output logic [RA_W-1:0]  rd_addr,
    input  logic [PIX_W-1:0] rd_data,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [WA_W-1:0]  wr_addr,
    output logic [PIX_W-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam int         c_xw         = $clog2(4 * SRC_W);
    localparam int         c_yw         = $clog2(4 * SRC_H);
    localparam int         c_accw       = PIX_W + 4;
    localparam logic [1:0] c_drain_last = 2'(RD_LAT - 1);

    // Frame configuration, latched at start
    logic [1:0]        r_alg;
    logic [1:0]        r_k;
    logic              r_zoom_in;
    logic [c_xw-1:0]   r_w_out_m1;
    logic [c_yw-1:0]   r_h_out_m1;
    logic [3:0]        r_taps_m1;
    logic [2:0]        r_avg_shift;

    // Progress
    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_state_nxt;
    logic [c_xw-1:0]   r_x;
    logic [c_yw-1:0]   r_y;
    logic [3:0]        r_tap;
    logic [1:0]        r_drain;
    logic [RD_LAT-1:0] r_rd_dly;
    logic [c_accw-1:0] r_acc;
    logic [WA_W-1:0]   r_wr_addr;
    logic              r_cfg_err;

    // Start-time configuration decode
    logic [1:0]        w_k;
    logic              w_zin;
    logic              w_is_avg;
    int                w_w_out;
    int                w_h_out;
    logic [c_xw-1:0]   w_w_out_m1;
    logic [c_yw-1:0]   w_h_out_m1;
    logic [3:0]        w_taps_m1;
    logic [2:0]        w_avg_shift;
    logic              w_start_ok;

    logic [RA_W-1:0]   w_src_addr;
    logic              w_last_pix;
    logic              w_handshake;

    always_comb begin
        w_k      = zoom_shift(zoom_level);
        w_zin    = zoom_level > c_zoom_one;
        w_is_avg = !w_zin && (algorithm == c_alg_avg);
        if (w_zin) begin
            w_w_out = SRC_W << w_k;
            w_h_out = SRC_H << w_k;
        end else begin
            w_w_out = SRC_W >> w_k;
            w_h_out = SRC_H >> w_k;
        end
        w_w_out_m1  = c_xw'(w_w_out - 1);
        w_h_out_m1  = c_yw'(w_h_out - 1);
        // Averaging fetches an FxF block (F*F = 1 << 2k taps); all else one tap.
        w_taps_m1   = w_is_avg ? 4'((5'd1 << {w_k, 1'b0}) - 5'd1) : 4'd0;
        w_avg_shift = w_is_avg ? {w_k, 1'b0} : 3'd0;
    end

    assign w_start_ok  = (r_state == c_st_idle) && start && (zoom_level <= c_max_zoom);
    assign w_last_pix  = (r_x == r_w_out_m1) && (r_y == r_h_out_m1);
    assign w_handshake = (r_state == c_st_emit) && wr_ready;

    image_scaler_engine_addr_gen #(
        .SRC_W (SRC_W),
        .RA_W  (RA_W),
        .XW    (c_xw),
        .YW    (c_yw)
    ) u_addr_gen (
        .i_x         (r_x),
        .i_y         (r_y),
        .i_k         (r_k),
        .i_zoom_in   (r_zoom_in),
        .i_algorithm (r_alg),
        .i_tap       (r_tap),
        .o_rd_addr   (w_src_addr)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_start_ok) w_state_nxt = c_st_fetch;
            c_st_fetch:  if (r_tap == r_taps_m1) w_state_nxt = c_st_drain;
            c_st_drain:  if (r_drain == c_drain_last) w_state_nxt = c_st_emit;
            c_st_emit:   if (wr_ready) w_state_nxt = w_last_pix ? c_st_finish : c_st_fetch;
            c_st_finish: w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign rd_en    = (r_state == c_st_fetch);
    assign rd_addr  = rd_en ? w_src_addr : '0;
    assign wr_valid = (r_state == c_st_emit);
    assign wr_addr  = r_wr_addr;
    assign wr_data  = PIX_W'(r_acc >> r_avg_shift);
    assign busy     = (r_state == c_st_fetch) || (r_state == c_st_drain) ||
                      (r_state == c_st_emit);
    assign done     = (r_state == c_st_finish);
    assign cfg_err  = r_cfg_err;

    // rd_en delay line: its last stage marks the cycle rd_data carries a tap.
    generate
        if (RD_LAT == 1) begin : g_dly_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_rd_dly <= '0;
                else       r_rd_dly <= rd_en;
            end
        end else begin : g_dly_chain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_rd_dly <= '0;
                else       r_rd_dly <= {r_rd_dly[RD_LAT-2:0], rd_en};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cfg_err   <= 1'b0;
            r_alg       <= '0;
            r_k         <= '0;
            r_zoom_in   <= 1'b0;
            r_w_out_m1  <= '0;
            r_h_out_m1  <= '0;
            r_taps_m1   <= '0;
            r_avg_shift <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_tap       <= '0;
            r_drain     <= '0;
            r_acc       <= '0;
            r_wr_addr   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= (r_state == c_st_idle) && start && (zoom_level > c_max_zoom);

            if (r_rd_dly[RD_LAT-1]) begin
                r_acc <= r_acc + c_accw'(rd_data);
            end

            if (w_start_ok) begin
                r_alg       <= algorithm;
                r_k         <= w_k;
                r_zoom_in   <= w_zin;
                r_w_out_m1  <= w_w_out_m1;
                r_h_out_m1  <= w_h_out_m1;
                r_taps_m1   <= w_taps_m1;
                r_avg_shift <= w_avg_shift;
                r_x         <= '0;
                r_y         <= '0;
                r_tap       <= '0;
                r_drain     <= '0;
                r_acc       <= '0;
                r_wr_addr   <= '0;
            end

            if (r_state == c_st_fetch) begin
                r_tap <= (r_tap == r_taps_m1) ? 4'd0 : r_tap + 4'd1;
            end

            if (r_state == c_st_drain) begin
                r_drain <= (r_drain == c_drain_last) ? 2'd0 : r_drain + 2'd1;
            end

            if (w_handshake) begin
                r_acc     <= '0;
                r_wr_addr <= r_wr_addr + WA_W'(1);
                if (r_x == r_w_out_m1) begin
                    r_x <= '0;
                    r_y <= r_y + c_yw'(1);
                end else begin
                    r_x <= r_x + c_xw'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_scaler_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_scaler_engine
// Description : Scoreboard bench for image_scaler_engine on a 4x4 source.
//               Expected writes come from a coordinate-level reference model;
//               a monitor pops and compares on every write handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_image_scaler_engine;

    localparam int SW  = 4;
    localparam int SH  = 4;
    localparam int PW  = 8;
    localparam int RAW = 4;
    localparam int WAW = 8;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     algorithm;
    logic [2:0]     zoom_level;
    logic           rd_en;
    logic [RAW-1:0] rd_addr;
    logic [PW-1:0]  rd_data;
    logic           wr_valid;
    logic           wr_ready;
    logic [WAW-1:0] wr_addr;
    logic [PW-1:0]  wr_data;
    logic           busy;
    logic           done;
    logic           cfg_err;

    image_scaler_engine #(
        .SRC_W(SW), .SRC_H(SH), .PIX_W(PW), .RA_W(RAW), .WA_W(WAW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .algorithm(algorithm),
        .zoom_level(zoom_level), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // ROM with LAT-cycle read pipeline
    logic [PW-1:0] rom      [SW*SH];
    logic [PW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom[rd_addr];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rd_data = rom_pipe[LAT-1];

    typedef struct { int addr; int data; } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, done_cnt = 0, cfg_cnt = 0, rd_cnt = 0, busy_cyc = 0;
    int rdy_mode = 0;
    int cyc = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference model: whole-frame expectation from the scaling rules.
    task automatic push_frame(input int alg, input int zoom, output int n);
        int k, f, wo, ho, d, s;
        k = (zoom >= 2) ? zoom - 2 : 2 - zoom;
        f = 1 << k;
        if (zoom >= 2) begin wo = SW * f; ho = SH * f; end
        else           begin wo = SW / f; ho = SH / f; end
        for (int y = 0; y < ho; y++) begin
            for (int x = 0; x < wo; x++) begin
                if (zoom >= 2) d = rom[(y / f) * SW + x / f];
                else if (alg == 0) d = rom[(y * f + f / 2) * SW + x * f + f / 2];
                else if (alg == 3) begin
                    s = 0;
                    for (int by = 0; by < f; by++)
                        for (int bx = 0; bx < f; bx++)
                            s += rom[(y * f + by) * SW + x * f + bx];
                    d = s / (f * f);
                end else d = rom[(y * f) * SW + x * f];
                sb.push_back('{addr: y * wo + x, data: d});
            end
        end
        n = wo * ho;
    endtask

    // wr_ready driver
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0: wr_ready = 1'b1;
                1: wr_ready = (cyc % 3 == 0);
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor
    logic           stalled = 1'b0;
    logic [WAW-1:0] held_addr;
    logic [PW-1:0]  held_data;
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_valid) begin
                if (stalled) begin
                    check("stall_addr_stable", int'(wr_addr), int'(held_addr));
                    check("stall_data_stable", int'(wr_data), int'(held_data));
                end
                if (wr_ready) begin
                    wr_cnt++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_write got_addr=%0d required=no write", wr_addr);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("wr_addr", int'(wr_addr), e.addr);
                        check("wr_data", int'(wr_data), e.data);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_addr = wr_addr;
                    held_data = wr_data;
                end
            end else stalled = 1'b0;
            if (busy)    busy_cyc++;
            if (done)    done_cnt++;
            if (cfg_err) cfg_cnt++;
            if (rd_en)   rd_cnt++;
        end else stalled = 1'b0;
    end

    task automatic do_start(input int alg, input int zoom);
        @(posedge clk); #2;
        algorithm  = 2'(alg);
        zoom_level = 3'(zoom);
        start      = 1'b1;
        @(posedge clk); #2;
        start      = 1'b0;
        // Scramble config while busy; it must have no effect.
        algorithm  = 2'($urandom);
        zoom_level = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk); #1;
            if (done) break;
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout waited=%0d cycles required=done", name, n);
        end
    endtask

    task automatic run_frame(input string name, input int alg, input int zoom, input int mode);
        int n, w0, d0;
        rdy_mode = mode;
        w0 = wr_cnt;
        d0 = done_cnt;
        push_frame(alg, zoom, n);
        do_start(alg, zoom);
        wait_done(name, 8000);
        @(negedge clk); #1;
        check({name, "_writes"}, wr_cnt - w0, n);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_busy_low"}, int'(busy), 0);
        check({name, "_sb_left"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic rom_ramp();
        for (int a = 0; a < SW * SH; a++) rom[a] = PW'(4 * a);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rd_en"},    int'(rd_en), 0);
        check({name, "_rd_addr"},  int'(rd_addr), 0);
        check({name, "_wr_valid"}, int'(wr_valid), 0);
        check({name, "_wr_addr"},  int'(wr_addr), 0);
        check({name, "_wr_data"},  int'(wr_data), 0);
        check({name, "_busy"},     int'(busy), 0);
        check({name, "_done"},     int'(done), 0);
        check({name, "_cfg_err"},  int'(cfg_err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout required=finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int b0, c0, r0, w0, d0, n;
        reset = 1'b1; start = 1'b0; algorithm = 2'd0; zoom_level = 3'd0;
        rom_ramp();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1x NN: one tap per pixel, T + LAT + 1 busy cycles each.
        b0 = busy_cyc;
        run_frame("nn_1x", 0, 2, 0);
        check("nn_1x_busy_cycles", busy_cyc - b0, SW * SH * (1 + LAT + 1));

        run_frame("avg_half", 3, 1, 0);

        b0 = busy_cyc;
        run_frame("avg_quarter", 3, 0, 0);
        check("avg_quarter_busy_cycles", busy_cyc - b0, 16 + LAT + 1);

        run_frame("repl_4x_stall", 1, 4, 1);
        run_frame("nn_quarter", 0, 0, 2);
        run_frame("decim_half", 2, 1, 2);

        // Illegal zoom: error pulse, no frame.
        c0 = cfg_cnt; r0 = rd_cnt; b0 = busy_cyc;
        do_start(0, 6);
        repeat (6) @(negedge clk);
        check("cfg_err_pulses", cfg_cnt - c0, 1);
        check("cfg_err_no_rd", rd_cnt - r0, 0);
        check("cfg_err_no_busy", busy_cyc - b0, 0);

        // Second start during busy is ignored.
        rdy_mode = 0;
        w0 = wr_cnt; d0 = done_cnt;
        push_frame(1, 3, n);
        do_start(1, 3);
        repeat (20) @(posedge clk);
        #2; start = 1'b1; zoom_level = 3'd2; algorithm = 2'd0;
        @(posedge clk); #2; start = 1'b0;
        wait_done("restart_ignored", 8000);
        repeat (100) @(negedge clk);
        check("restart_ignored_writes", wr_cnt - w0, n);
        check("restart_ignored_done", done_cnt - d0, 1);
        check("restart_ignored_sb_left", sb.size(), 0);
        sb.delete();

        // Reset while pixel 7 is being fetched.
        rdy_mode = 0;
        w0 = wr_cnt; d0 = done_cnt;
        push_frame(1, 3, n);
        do_start(1, 3);
        n = 0;
        while ((wr_cnt - w0) < 7 && n < 500) begin @(negedge clk); n++; end
        check("midframe_reached_px7", wr_cnt - w0, 7);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        #2; reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midframe_no_done", done_cnt - d0, 0);
        run_frame("after_reset", 1, 3, 0);

        // Randomised frames with random ROM contents and backpressure.
        for (int t = 0; t < 8; t++) begin
            for (int a = 0; a < SW * SH; a++) rom[a] = PW'($urandom);
            run_frame($sformatf("rand%0d", t), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
